// File: rtl/controller_port.sv
// NES-style controller port: polls a serial pad, debounces the result and serves
// it to the CPU through the usual $4016 strobe / shift-register protocol.

module controller_port_checker (
  input logic clock,
  input logic reset_n,
  input logic pad_latch,
  input logic pad_pulse,
  input logic poll_busy
);

  // Latch and clock lines toward the pad must never be driven together.
  latch_pulse_exclusive_a : assert property (
    @(posedge clock) disable iff (!reset_n) !(pad_latch && pad_pulse)
  );

  // Any pad-side activity belongs to a poll in progress.
  pad_lines_busy_a : assert property (
    @(posedge clock) disable iff (!reset_n) ((pad_latch || pad_pulse) -> poll_busy)
  );

endmodule

module controller_port #(
  parameter logic [19:0] POLL_PERIOD = 20'd833333,
  parameter logic [9:0]  HALF_BIT    = 10'd300
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_en,
  input  logic       strobe_wr,
  input  logic       strobe_val,
  input  logic       read_en,
  output logic       ctlr_data,
  output logic       pad_latch,
  output logic       pad_pulse,
  input  logic       pad_data,
  output logic [7:0] buttons,
  output logic       poll_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    BIT_LO = 2'd2,
    BIT_HI = 2'd3
  } poll_state_t;

  localparam logic [19:0] IDLE_LAST = POLL_PERIOD - 20'd1;
  localparam logic [19:0] HALF_LAST = {10'd0, HALF_BIT} - 20'd1;
  localparam logic [19:0] FULL_LAST = {9'd0, HALF_BIT, 1'b0} - 20'd1;

  logic        pad_meta_r;
  logic        pad_sync_r;
  poll_state_t state_r;
  logic [19:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  raw_r;
  logic [7:0]  prev_raw_r;
  logic [7:0]  buttons_r;
  logic        pad_latch_r;
  logic        pad_pulse_r;
  logic        busy_r;
  logic        strobe_r;
  logic [7:0]  sr_r;

  logic [19:0] lo_last_s;
  logic [7:0]  raw_next_s;

  // Two-flop synchronizer for the asynchronous pad data line (idles high).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pad_meta_r <= 1'b1;
      pad_sync_r <= 1'b1;
    end else begin
      pad_meta_r <= pad_data;
      pad_sync_r <= pad_meta_r;
    end
  end

  // The final low phase is held a full bit so a poll spans 18 half-bits in total;
  // the raw image with the current bit merged lets the commit see bit 7 immediately.
  always_comb begin
    lo_last_s  = HALF_LAST;
    raw_next_s = raw_r;
    if (idx_r == 3'd7) begin
      lo_last_s = FULL_LAST;
    end else begin
      lo_last_s = HALF_LAST;
    end
    raw_next_s[idx_r] = ~pad_sync_r;
  end

  // Poll FSM: idle wait, latch pulse, eight bit slots, then debounced commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 20'd0;
      idx_r       <= 3'd0;
      raw_r       <= 8'h00;
      prev_raw_r  <= 8'h00;
      buttons_r   <= 8'h00;
      pad_latch_r <= 1'b0;
      pad_pulse_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cnt_r == IDLE_LAST) begin
            state_r     <= LATCH;
            cnt_r       <= 20'd0;
            idx_r       <= 3'd0;
            pad_latch_r <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        LATCH: begin
          if (cnt_r == FULL_LAST) begin
            state_r     <= BIT_LO;
            cnt_r       <= 20'd0;
            pad_latch_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        BIT_LO: begin
          if (cnt_r == lo_last_s) begin
            cnt_r <= 20'd0;
            raw_r <= raw_next_s;
            if (idx_r != 3'd7) begin
              state_r     <= BIT_HI;
              pad_pulse_r <= 1'b1;
            end else begin
              // Accept a new snapshot only when two consecutive polls agree.
              prev_raw_r <= raw_next_s;
              if (raw_next_s == prev_raw_r) begin
                buttons_r <= raw_next_s;
              end
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        BIT_HI: begin
          if (cnt_r == HALF_LAST) begin
            state_r     <= BIT_LO;
            cnt_r       <= 20'd0;
            idx_r       <= idx_r + 3'd1;
            pad_pulse_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 20'd0;
          idx_r       <= 3'd0;
          pad_latch_r <= 1'b0;
          pad_pulse_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // CPU side: strobe register and the read shift register (fills with 1s).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_r <= 1'b0;
      sr_r     <= 8'h00;
    end else if (clock_en) begin
      if (strobe_r) begin
        sr_r <= buttons_r;
      end else if (read_en && !strobe_wr) begin
        sr_r <= {1'b1, sr_r[7:1]};
      end
      if (strobe_wr) begin
        strobe_r <= strobe_val;
      end
    end
  end

  assign ctlr_data = strobe_r ? ~buttons_r[0] : ~sr_r[0];
  assign pad_latch = pad_latch_r;
  assign pad_pulse = pad_pulse_r;
  assign buttons   = buttons_r;
  assign poll_busy = busy_r;

  controller_port_checker u_checker (
    .clock     (clock),
    .reset_n   (reset_n),
    .pad_latch (pad_latch_r),
    .pad_pulse (pad_pulse_r),
    .poll_busy (busy_r)
  );

endmodule

// File: tb/tb_controller_port.sv
// Bench for controller_port: pad model, debounce model and CPU read-order model.

module tb_controller_port;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clock_en = 1'b0;
  logic       strobe_wr = 1'b0;
  logic       strobe_val = 1'b0;
  logic       read_en = 1'b0;
  logic       pad_data = 1'b1;
  logic       ctlr_data;
  logic       pad_latch;
  logic       pad_pulse;
  logic       poll_busy;
  logic [7:0] buttons;

  logic [7:0] pad_buttons = 8'h09;
  logic [7:0] pad_sh = 8'hFF;
  logic       pulse_q = 1'b0;

  int         total = 0;
  int         bad = 0;

  logic [7:0] m_btn = 8'h00;
  logic [7:0] m_prev = 8'h00;
  logic       m_strobe = 1'b0;
  logic [7:0] m_snap = 8'h00;
  int         m_ridx = 0;
  logic       last_read;

  controller_port #(
    .POLL_PERIOD (20'd100),
    .HALF_BIT    (10'd4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clock_en   (clock_en),
    .strobe_wr  (strobe_wr),
    .strobe_val (strobe_val),
    .read_en    (read_en),
    .ctlr_data  (ctlr_data),
    .pad_latch  (pad_latch),
    .pad_pulse  (pad_pulse),
    .pad_data   (pad_data),
    .buttons    (buttons),
    .poll_busy  (poll_busy)
  );

  always #5 clock = ~clock;

  // Physical pad: 4021-style shift register, active-low output.
  always @(negedge clock) begin
    if (pad_latch) pad_sh = ~pad_buttons;
    else if (pad_pulse && !pulse_q) pad_sh = {1'b1, pad_sh[7:1]};
    pulse_q  = pad_pulse;
    pad_data = pad_sh[0];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic commit(input logic [7:0] v);
    if (v == m_prev) m_btn = v;
    m_prev = v;
  endtask

  task automatic wait_idle();
    int  g = 0;
    bit  was = 0;
    while (poll_busy && g < 4000) begin
      was = 1;
      @(posedge clock); #1;
      g++;
    end
    check("idle_timeout", g < 4000, 1);
    if (was) commit(pad_buttons);
  endtask

  task automatic run_poll(input bit measure);
    int   gap = 0, len = 0, lat = 0, pul = 0, hold_err = 0, guard = 0;
    logic pq = 1'b0;
    wait_idle();
    while (!poll_busy && guard < 4000) begin
      @(posedge clock); #1;
      gap++; guard++;
    end
    while (poll_busy && guard < 4000) begin
      len++;
      if (pad_latch) lat++;
      if (pad_pulse && !pq) pul++;
      pq = pad_pulse;
      if (buttons !== m_btn) hold_err++;
      @(posedge clock); #1;
      guard++;
    end
    check("poll_timeout", guard < 4000, 1);
    commit(pad_buttons);
    if (measure) check("poll_gap", gap, 100);
    check("poll_len", len, 72);
    check("latch_len", lat, 8);
    check("pulse_cnt", pul, 7);
    check("btn_hold", hold_err, 0);
    check("buttons", buttons, m_btn);
  endtask

  task automatic cpu_cycle(input bit en, input bit wr, input bit val, input bit rd);
    @(negedge clock);
    clock_en = en; strobe_wr = wr; strobe_val = val; read_en = rd;
    #1 last_read = ctlr_data;
    @(posedge clock); #1;
    clock_en = 1'b0; strobe_wr = 1'b0; strobe_val = 1'b0; read_en = 1'b0;
  endtask

  function automatic logic cpu_expect();
    if (m_strobe) return ~m_btn[0];
    else if (m_ridx < 8) return ~m_snap[m_ridx];
    else return 1'b0;
  endfunction

  task automatic model_cpu(input bit en, input bit wr, input bit val, input bit rd);
    if (en) begin
      if (m_strobe) begin
        m_snap = m_btn;
        m_ridx = 0;
      end else if (rd && !wr && m_ridx < 8) begin
        m_ridx++;
      end
      if (wr) m_strobe = val;
    end
  endtask

  initial begin
    logic [9:0] seq;
    logic [7:0] pats [5];
    logic [7:0] v;
    int         pul;
    int         g;
    logic       pq;
    bit         en, wr, val, rd;
    logic       e;

    pats = '{8'h00, 8'h02, 8'h5A, 8'hFF, 8'h81};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_ctlr_data", ctlr_data, 1'b1);
    check("rst_buttons", buttons, 8'h00);
    check("rst_busy", poll_busy, 1'b0);
    check("rst_latch", pad_latch, 1'b0);
    check("rst_pulse", pad_pulse, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Two polls of A+Start: debounce needs the second one
    run_poll(1);
    check("poll1_btn", buttons, 8'h00);
    run_poll(1);
    check("poll2_btn", buttons, 8'h09);

    // Strobe 1/0 then ten reads, with a disabled access in the middle
    seq = 10'b0011110110;
    cpu_cycle(1, 1, 1, 0);
    cpu_cycle(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cpu_cycle(1, 0, 0, 1);
      check("read_seq", last_read, seq[i]);
      if (i == 4) begin
        cpu_cycle(0, 1, 1, 1);
        check("no_en_hold", last_read, seq[5]);
      end
    end

    // Randomized CPU traffic against the read-order model
    cpu_cycle(1, 1, 1, 0);
    m_strobe = 1'b1;
    m_ridx   = 0;
    for (int i = 0; i < 300; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 7) == 0);
      val = $urandom_range(0, 1);
      rd  = $urandom_range(0, 1);
      e   = cpu_expect();
      cpu_cycle(en, wr, val, rd);
      check("rand_read", last_read, e);
      model_cpu(en, wr, val, rd);
    end

    // A buttons update during strobe=0 must not disturb the loaded sr
    cpu_cycle(1, 1, 1, 0);
    cpu_cycle(1, 1, 0, 0);
    wait_idle();
    pad_buttons = 8'h01;
    run_poll(1);
    run_poll(1);
    check("btn_now_01", buttons, 8'h01);
    for (int i = 0; i < 8; i++) begin
      cpu_cycle(1, 0, 0, 1);
      check("old_snapshot", last_read, seq[i]);
    end
    // Write and read together after 8 shifts
    cpu_cycle(1, 1, 1, 1);
    check("wr_rd_same", last_read, 1'b0);
    cpu_cycle(1, 0, 0, 0);
    // Reads while strobe held high
    for (int i = 0; i < 3; i++) begin
      cpu_cycle(1, 0, 0, 1);
      check("strobe_hi_read", last_read, 1'b0);
    end
    cpu_cycle(1, 1, 0, 0);
    cpu_cycle(1, 0, 0, 1);
    check("reload_bit0", last_read, 1'b0);
    cpu_cycle(1, 0, 0, 1);
    check("reload_bit1", last_read, 1'b1);

    // Glitchy single poll must never reach buttons
    wait_idle();
    pad_buttons = 8'h02;
    run_poll(0);
    run_poll(1);
    check("glitch_pre", buttons, 8'h02);
    pad_buttons = 8'hFF;
    run_poll(1);
    check("glitch_mid", buttons, 8'h02);
    pad_buttons = 8'h02;
    run_poll(1);
    check("glitch_post", buttons, 8'h02);

    // Random pad patterns with frequent repeats
    v = 8'h02;
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) v = pats[$urandom_range(0, 4)];
      pad_buttons = v;
      run_poll(1);
    end

    // Reset during BIT_HI of bit 3
    pad_buttons = 8'h09;
    wait_idle();
    g = 0;
    while (!poll_busy && g < 4000) begin @(posedge clock); #1; g++; end
    pul = 0;
    pq  = 1'b0;
    while (pul < 4 && g < 4000) begin
      if (pad_pulse && !pq) pul++;
      pq = pad_pulse;
      if (pul < 4) begin @(posedge clock); #1; g++; end
    end
    check("bit3_found", pul, 4);
    #1 reset_n = 1'b0;
    #1;
    check("arst_pulse", pad_pulse, 1'b0);
    check("arst_latch", pad_latch, 1'b0);
    check("arst_busy", poll_busy, 1'b0);
    check("arst_buttons", buttons, 8'h00);
    check("arst_ctlr", ctlr_data, 1'b1);
    m_btn  = 8'h00;
    m_prev = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_poll(1);
    check("post_rst_btn", buttons, 8'h00);
    run_poll(1);
    check("post_rst_btn2", buttons, 8'h09);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
